shift_seq_unit: RTL and testbench

Multi-cycle sequencer for logical and arithmetic shifts on a DATA_W-bit operand, built from byte-step and residual-bit passes instead of a full barrel shifter. It sits between the RV32I execute stage and the writeback path. It takes one shift request at a time over a valid/ready handshake and returns the result over a second valid/ready handshake. It trades latency (up to 4 cycles for 32-bit) for area.

---
 rtl/shift_seq_unit.sv | 181 ++++++++++++++++++
 tb/tb_shift_seq_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_unit.sv
// shift_seq_unit: multi-cycle SLL/SRL/SRA sequencer built from byte-step
// (COARSE) passes followed by one residual-bit (FINE) pass.
// Optional feature macro: SHIFT_SEQ_FASTPATH_EN
//   defined   -> shamt==0 / illegal-op requests go straight to DONE, and a
//                byte-aligned shift skips FINE after its last COARSE pass.
//   undefined -> every request passes through FINE (latency N+1).
// Assumes DATA_W >= 16 so that the byte-count field is at least one bit.
//
// Handshake contract: a transfer happens on a rising edge where valid and
// ready are both high; req_ready is high only in IDLE, rsp_valid only in DONE,
// and rsp_data/rsp_err stay stable while rsp_valid is waiting for rsp_ready.
module shift_seq_unit #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [DATA_W-1:0]  req_data,
    input  logic [SHAMT_W-1:0] req_shamt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    localparam int NW = SHAMT_W - 3;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COARSE = 2'd1,
        FINE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   work_q;
    logic [NW-1:0]       n_q;
    logic [2:0]          r_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q;

    logic                accept;
    logic                done_load;
    logic [DATA_W-1:0]   done_val;
    logic                done_err;
    logic [DATA_W-1:0]   coarse_val;
    logic [DATA_W-1:0]   fine_val;

    // Shift with the op's fill rule; SRA sign comes from the value being
    // shifted, so repeated passes keep the sign. Illegal op passes through.
    function automatic logic [DATA_W-1:0] shift_by(
        input logic [DATA_W-1:0]  v,
        input logic [1:0]         op,
        input logic [SHAMT_W-1:0] amt
    );
        logic [DATA_W-1:0] res;
        case (op)
            OP_SLL:  res = v << amt;
            OP_SRL:  res = v >> amt;
            OP_SRA:  res = DATA_W'($signed(v) >>> amt);
            default: res = v;
        endcase
        return res;
    endfunction

    assign accept     = req_valid && (state_q == IDLE);
    assign coarse_val = shift_by(work_q, op_q, SHAMT_W'(8));
    assign fine_val   = shift_by(work_q, op_q, SHAMT_W'(r_q));

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign dbg_state  = state_q;

    // State register; reset abandons any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the value/error to capture on DONE entry.
    always_comb begin
        state_d   = state_q;
        done_load = 1'b0;
        done_val  = '0;
        done_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef SHIFT_SEQ_FASTPATH_EN
                    if ((req_shamt == '0) || (req_op == OP_ILL)) begin
                        state_d   = DONE;
                        done_load = 1'b1;
                        done_val  = req_data;
                        done_err  = (req_op == OP_ILL);
                    end else
`endif
                    if (req_shamt[SHAMT_W-1:3] != '0) begin
                        state_d = COARSE;
                    end else begin
                        state_d = FINE;
                    end
                end
            end
            COARSE: begin
                if (n_q == NW'(1)) begin
`ifdef SHIFT_SEQ_FASTPATH_EN
                    if (r_q == 3'd0) begin
                        state_d   = DONE;
                        done_load = 1'b1;
                        done_val  = coarse_val;
                        done_err  = (op_q == OP_ILL);
                    end else begin
                        state_d = FINE;
                    end
`else
                    state_d = FINE;
`endif
                end
            end
            FINE: begin
                state_d   = DONE;
                done_load = 1'b1;
                done_val  = fine_val;
                done_err  = (op_q == OP_ILL);
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Working registers: load on accept, step one byte per COARSE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_SLL;
            work_q <= '0;
            n_q    <= '0;
            r_q    <= 3'd0;
        end else if (accept) begin
            op_q   <= req_op;
            work_q <= req_data;
            n_q    <= req_shamt[SHAMT_W-1:3];
            r_q    <= req_shamt[2:0];
        end else if (state_q == COARSE) begin
            work_q <= coarse_val;
            n_q    <= n_q - NW'(1);
        end
    end

    // Response registers change only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (done_load) begin
            rsp_data_q <= done_val;
            rsp_err_q  <= done_err;
        end
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// tb_shift_seq_unit: directed vectors with hand-computed results for
// shift_seq_unit (DATA_W=32). Latency expectations follow whether
// SHIFT_SEQ_FASTPATH_EN is defined for the build.
module tb_shift_seq_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic [4:0]  req_shamt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [1:0]  dbg_state;

    int tests_run;
    int tests_failed;
    logic [31:0] exp_q[$];

    shift_seq_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_shamt (req_shamt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected latency (edges after E0 until rsp_valid) from the shift amount.
    function automatic int exp_lat(input logic [1:0] op, input logic [4:0] shamt);
        int n;
        int r;
        n = int'(shamt[4:3]);
        r = int'(shamt[2:0]);
`ifdef SHIFT_SEQ_FASTPATH_EN
        if (shamt == 5'd0 || op == 2'b11) return 0;
        if (n > 0 && r == 0) return n;
        return n + 1;
`else
        if (op == 2'b11) return n + 1;
        return n + 1;
`endif
    endfunction

    // Driver: present a request at the negedge; returns at E0 + #1.
    task automatic send(input logic [1:0] op, input logic [31:0] data, input logic [4:0] shamt);
        @(negedge clk);
        check("req_ready_before_send", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        req_shamt = shamt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = 32'h0;
        req_shamt = 5'd0;
        req_op    = 2'b00;
    endtask

    // Wait for the response, check it against the scoreboard, then consume it
    // after holding rsp_ready low for 'hold' cycles.
    task automatic expect_rsp(input logic err, input int lat, input int hold);
        int cyc;
        int busy_cnt;
        logic [31:0] exp;
        cyc = 0;
        busy_cnt = 0;
        while (!rsp_valid && cyc < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
        check("latency", 32'(cyc), 32'(lat));
        check("busy_cycles", 32'(busy_cnt), 32'(lat));
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
            exp = 32'h0;
        end else begin
            exp = exp_q.pop_front();
        end
        check("rsp_data", rsp_data, exp);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, err});
        check("req_ready_in_done", {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_data", rsp_data, exp);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("post_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_req_ready", {31'd0, req_ready}, 32'd1);
        check("post_busy", {31'd0, busy}, 32'd0);
        check("post_data_held", rsp_data, exp);
    endtask

    task automatic run_vec(input logic [1:0] op, input logic [31:0] data, input logic [4:0] shamt,
                           input logic [31:0] exp, input logic err, input int hold);
        exp_q.push_back(exp);
        send(op, data, shamt);
        expect_rsp(err, exp_lat(op, shamt), hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rsp_data"}, rsp_data, 32'h0);
        check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        req_valid    = 1'b0;
        req_op       = 2'b00;
        req_data     = 32'h0;
        req_shamt    = 5'd0;
        rsp_ready    = 1'b0;

        // Reset
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Warm-up so rsp_data is nonzero before the mid-operation reset
        run_vec(2'b00, 32'h0000_0001, 5'd1, 32'h0000_0002, 1'b0, 0);

        // Reset mid-operation: SRA 0x80000000 by 31, reset after E0+2
        send(2'b10, 32'h8000_0000, 5'd31);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("midreset_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        run_vec(2'b00, 32'h0000_0001, 5'd1, 32'h0000_0002, 1'b0, 0);

        // Arithmetic, worst-case latency
        run_vec(2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 0);
        // Coarse plus fine with 5 cycles of backpressure
        run_vec(2'b00, 32'h0000_0001, 5'd9, 32'h0000_0200, 1'b0, 5);
        // Fine only
        run_vec(2'b01, 32'hF000_0000, 5'd4, 32'h0F00_0000, 1'b0, 0);
        run_vec(2'b01, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0, 0);
        // Byte-aligned
        run_vec(2'b01, 32'hAABB_CCDD, 5'd16, 32'h0000_AABB, 1'b0, 0);
        // Illegal op then a legal SRA
        run_vec(2'b11, 32'hDEAD_BEEF, 5'd5, 32'hDEAD_BEEF, 1'b1, 0);
        run_vec(2'b10, 32'h7FFF_FFFF, 5'd8, 32'h007F_FFFF, 1'b0, 0);
        // Sign fill across a byte pass and residual, and a max SLL
        run_vec(2'b10, 32'h8000_0000, 5'd12, 32'hFFF8_0000, 1'b0, 1);
        run_vec(2'b00, 32'hAABB_CCDD, 5'd24, 32'hDD00_0000, 1'b0, 0);
        run_vec(2'b01, 32'h8000_0001, 5'd31, 32'h0000_0001, 1'b0, 0);
        run_vec(2'b11, 32'hCAFE_F00D, 5'd24, 32'hCAFE_F00D, 1'b1, 2);

        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
